hub75_rx: RTL and testbench

- Receiving end of the LED-matrix HUB75 interface: samples CLK_MATRIX, LATCH, OE, RGB1, RGB2 and ROW_ADDRESS as driven by the matrix driver, and rebuilds the shifted row data.
- Emits a pixel stream (row, column, 3-bit colour) for on-chip loopback checking and capture of what the panel would display.
- Sits beside the matrix driver in the MCLK domain; treats all HUB75 inputs as asynchronous.

---
 rtl/hub75_pkg.sv | 13 +
 rtl/hub75_rx_if.sv | 11 +
 rtl/hub75_sync.sv | 25 ++
 rtl/hub75_rx.sv | 98 +++++++++
 tb/tb_hub75_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared colour indices, readout states and sizing helper for the HUB75 receiver.
package hub75_pkg;
  localparam int R = 2;
  localparam int G = 1;
  localparam int B = 0;
  typedef enum logic [1:0] {IDLE, UPPER, LOWER} fsm_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if: HUB75 panel-side signal bundle as driven by the matrix driver.
interface hub75_rx_if #(parameter int ADDR_W = 4);
  logic              CLK_MATRIX;
  logic              LATCH;
  logic              OE;
  logic [2:0]        RGB1;
  logic [2:0]        RGB2;
  logic [ADDR_W-1:0] ROW_ADDRESS;
  modport master (output CLK_MATRIX, LATCH, OE, RGB1, RGB2, ROW_ADDRESS);
  modport slave  (input  CLK_MATRIX, LATCH, OE, RGB1, RGB2, ROW_ADDRESS);
endinterface

// File: rtl/hub75_sync.sv
// hub75_sync: N-stage synchroniser with a rising-edge strobe taken from the last stage.
module hub75_sync #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [N-1:0][W-1:0] s;
  logic [W-1:0]        q_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s   <= '0;
      q_d <= '0;
    end else begin
      s[0] <= d;
      for (int i = 1; i < N; i++) s[i] <= s[i-1];
      q_d <= q;
    end
  assign q    = s[N-1];
  assign rise = q & ~q_d;
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: rebuilds shifted HUB75 row pairs and replays them as a registered pixel stream.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = 32,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   MCLK,
  input  logic                   RESET,
  hub75_rx_if.slave              hub,
  output logic                   pix_valid,
  output logic [ADDR_W:0]        pix_row,
  output logic [clog2(COLS)-1:0] pix_col,
  output logic [2:0]             pix_rgb,
  output logic                   row_done,
  output logic                   len_err,
  output logic                   overflow,
  output logic                   oe_active
);
  localparam int CW = clog2(COLS);
  localparam int NW = clog2(COLS + 2);
  localparam int DW = 7 + ADDR_W;
  logic              clk_rise, lat_rise, clk_q_unused, lat_q_unused;
  logic [DW-1:0]     dat_s, dat_rise_unused;
  logic [2:0]        rgb1_s, rgb2_s;
  logic [ADDR_W-1:0] addr_s, addr_h;
  logic [COLS-1:0][2:0] up_sr, lo_sr, up_h, lo_h;
  logic [NW-1:0]     cnt;
  logic [CW-1:0]     col, col_d;
  fsm_t              state, state_d;
  logic              full, accept, last;
  hub75_sync #(.N(SYNC_STAGES), .W(1)) u_clk (
    .clk(MCLK), .rst_n(RESET), .d(hub.CLK_MATRIX), .q(clk_q_unused), .rise(clk_rise)
  );
  hub75_sync #(.N(SYNC_STAGES), .W(1)) u_lat (
    .clk(MCLK), .rst_n(RESET), .d(hub.LATCH), .q(lat_q_unused), .rise(lat_rise)
  );
  // OE is inverted before the synchroniser so a cleared chain reads as "panel dark"
  hub75_sync #(.N(SYNC_STAGES), .W(DW)) u_dat (
    .clk(MCLK), .rst_n(RESET), .d({~hub.OE, hub.RGB1, hub.RGB2, hub.ROW_ADDRESS}),
    .q(dat_s), .rise(dat_rise_unused)
  );
  assign {oe_active, rgb1_s, rgb2_s, addr_s} = dat_s;
  assign full   = cnt == NW'(COLS);
  assign accept = lat_rise && full && state == IDLE;
  assign last   = col == CW'(COLS - 1);
  always_ff @(posedge MCLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      col   <= '0;
    end else begin
      state <= state_d;
      col   <= col_d;
    end
  always_comb begin
    state_d = state == IDLE  ? (accept ? UPPER : IDLE) :
              state == UPPER ? (last ? LOWER : UPPER) :
                               (last ? IDLE : LOWER);
    col_d   = (state == IDLE || last) ? '0 : col + 1'b1;
  end
  always_ff @(posedge MCLK or negedge RESET)
    if (!RESET) begin
      up_sr     <= '0;
      lo_sr     <= '0;
      up_h      <= '0;
      lo_h      <= '0;
      addr_h    <= '0;
      cnt       <= '0;
      len_err   <= 1'b0;
      overflow  <= 1'b0;
      pix_valid <= 1'b0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_rgb   <= '0;
      row_done  <= 1'b0;
    end else begin
      if (clk_rise) begin
        up_sr <= {rgb1_s, up_sr[COLS-1:1]};
        lo_sr <= {rgb2_s, lo_sr[COLS-1:1]};
      end
      // a shift edge coinciding with the latch edge belongs to the next row
      cnt <= lat_rise ? NW'(clk_rise) :
             (clk_rise && cnt != NW'(COLS + 1)) ? cnt + 1'b1 : cnt;
      if (accept) begin
        up_h   <= up_sr;
        lo_h   <= lo_sr;
        addr_h <= addr_s;
      end
      len_err   <= lat_rise && !full;
      overflow  <= overflow | (lat_rise && full && state != IDLE);
      pix_valid <= state != IDLE;
      pix_row   <= {state == LOWER, addr_h};
      pix_col   <= col;
      pix_rgb   <= state == LOWER ? lo_h[col] : up_h[col];
      row_done  <= state == LOWER && last;
    end
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed HUB75 receive scenarios checked with immediate assertions.
module tb_hub75_rx;
  localparam int COLS = 32;
  localparam int ADDR_W = 4;
  logic MCLK = 1'b0;
  logic RESET = 1'b0;
  logic pix_valid, row_done, len_err, overflow, oe_active;
  logic [ADDR_W:0] pix_row;
  logic [4:0] pix_col;
  logic [2:0] pix_rgb;
  int n_asrt = 0;
  int n_fail = 0;
  logic [12:0] pix_q[$];
  int rd_cnt = 0, rd_idx = 0, le_cnt = 0, oe_hi = 0, run = 0, last_run = 0;

  always #10 MCLK = ~MCLK;

  hub75_rx_if #(.ADDR_W(ADDR_W)) hub ();

  hub75_rx #(.COLS(COLS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .MCLK(MCLK), .RESET(RESET), .hub(hub),
    .pix_valid(pix_valid), .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
    .row_done(row_done), .len_err(len_err), .overflow(overflow), .oe_active(oe_active)
  );

  always @(negedge MCLK) begin
    if (pix_valid) begin
      pix_q.push_back({pix_row, pix_col, pix_rgb});
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (row_done) begin
      rd_cnt++;
      rd_idx = pix_q.size();
    end
    if (len_err) le_cnt++;
    if (oe_active) oe_hi++;
  end

  function automatic logic [2:0] exp_up(input int k, input int c);
    return k == 0 ? 3'(c % 8) : k == 1 ? 3'd7 : k == 2 ? 3'((c * 3) % 8) : 3'((c + 5) % 8);
  endfunction

  function automatic logic [2:0] exp_lo(input int k, input int c);
    return k == 0 ? 3'(7 - c % 8) : k == 1 ? 3'd7 : k == 2 ? 3'(c % 4) : 3'((c / 4) % 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_px(input logic [2:0] a, input logic [2:0] b);
    @(negedge MCLK);
    hub.CLK_MATRIX = 1'b0;
    hub.RGB1 = a;
    hub.RGB2 = b;
    repeat (3) @(negedge MCLK);
    hub.CLK_MATRIX = 1'b1;
    repeat (3) @(negedge MCLK);
  endtask

  task automatic shift_row(input int k, input int n);
    for (int c = 0; c < n; c++) drv_px(exp_up(k, c % 32), exp_lo(k, c % 32));
  endtask

  task automatic latch();
    @(negedge MCLK);
    hub.LATCH = 1'b1;
    repeat (3) @(negedge MCLK);
    hub.LATCH = 1'b0;
  endtask

  task automatic clr();
    @(posedge MCLK);
    pix_q.delete();
    rd_cnt = 0;
    rd_idx = 0;
    le_cnt = 0;
    oe_hi = 0;
    run = 0;
    last_run = 0;
  endtask

  task automatic chk_row(input int addr, input int k);
    chk("pixel_count", pix_q.size(), 64);
    chk("row_done_count", rd_cnt, 1);
    chk("row_done_index", rd_idx, 64);
    chk("valid_run", last_run, 64);
    chk("len_err_count", le_cnt, 0);
    for (int i = 0; i < 64 && i < pix_q.size(); i++)
      chk("pixel", pix_q[i], {5'(i < 32 ? addr : addr + 16), 5'(i % 32),
                              i < 32 ? exp_up(k, i % 32) : exp_lo(k, i % 32)});
  endtask

  initial begin
    hub.CLK_MATRIX = 1'b0;
    hub.LATCH = 1'b0;
    hub.OE = 1'b0;
    hub.RGB1 = '0;
    hub.RGB2 = '0;
    hub.ROW_ADDRESS = '0;
    repeat (5) @(negedge MCLK);
    chk("reset_outputs", {pix_valid, row_done, len_err, overflow, oe_active, pix_row, pix_col, pix_rgb}, 0);
    hub.OE = 1'b1;
    @(negedge MCLK);
    RESET = 1'b1;

    hub.ROW_ADDRESS = 4'd5;
    shift_row(0, 32);
    clr();
    latch();
    repeat (200) @(negedge MCLK);
    chk_row(5, 0);
    chk("overflow_clear", overflow, 0);

    hub.ROW_ADDRESS = 4'd15;
    shift_row(1, 32);
    clr();
    latch();
    repeat (200) @(negedge MCLK);
    chk_row(15, 1);

    shift_row(0, 31);
    clr();
    latch();
    repeat (50) @(negedge MCLK);
    chk("short_len_err", le_cnt, 1);
    chk("short_no_pixels", pix_q.size(), 0);

    shift_row(2, 33);
    clr();
    latch();
    repeat (50) @(negedge MCLK);
    chk("long_len_err", le_cnt, 1);
    chk("long_no_pixels", pix_q.size(), 0);

    hub.ROW_ADDRESS = 4'd3;
    shift_row(2, 32);
    @(negedge MCLK);
    hub.CLK_MATRIX = 1'b0;
    hub.RGB1 = 3'd7;
    hub.RGB2 = 3'd7;
    repeat (3) @(negedge MCLK);
    clr();
    @(negedge MCLK);
    hub.LATCH = 1'b1;
    hub.CLK_MATRIX = 1'b1;
    for (int j = 1; j < 32; j++) begin
      @(negedge MCLK);
      hub.LATCH = 1'b0;
      hub.ROW_ADDRESS = 4'd9;
      hub.CLK_MATRIX = 1'b0;
      @(negedge MCLK);
      hub.CLK_MATRIX = 1'b1;
    end
    @(negedge MCLK);
    hub.CLK_MATRIX = 1'b0;
    hub.LATCH = 1'b1;
    repeat (3) @(negedge MCLK);
    hub.LATCH = 1'b0;
    repeat (200) @(negedge MCLK);
    chk_row(3, 2);
    chk("overflow_set", overflow, 1);
    repeat (50) @(negedge MCLK);
    chk("overflow_sticky", overflow, 1);

    hub.ROW_ADDRESS = 4'd6;
    shift_row(3, 32);
    clr();
    latch();
    for (int w = 0; w < 300 && pix_q.size() < 10; w++) begin
      @(negedge MCLK);
      #1;
    end
    chk("reached_pixel_10", pix_q.size(), 10);
    RESET = 1'b0;
    #1;
    chk("reset_mid_readout", {pix_valid, row_done, len_err, overflow, oe_active, pix_row, pix_col, pix_rgb}, 0);
    hub.CLK_MATRIX = 1'b0;
    repeat (3) @(negedge MCLK);
    RESET = 1'b1;
    hub.ROW_ADDRESS = 4'd2;
    shift_row(3, 32);
    clr();
    latch();
    repeat (200) @(negedge MCLK);
    chk_row(2, 3);
    chk("overflow_after_reset", overflow, 0);

    hub.ROW_ADDRESS = 4'd1;
    shift_row(0, 32);
    clr();
    @(negedge MCLK);
    hub.LATCH = 1'b1;
    @(posedge MCLK);
    repeat (2) @(posedge MCLK);
    #1;
    chk("latency_edge_n2", pix_valid, 0);
    @(posedge MCLK);
    #1;
    chk("latency_edge_n3", pix_valid, 1);
    @(negedge MCLK);
    hub.LATCH = 1'b0;
    repeat (200) @(negedge MCLK);
    chk_row(1, 0);

    clr();
    @(negedge MCLK);
    hub.OE = 1'b0;
    @(posedge MCLK);
    #1;
    chk("oe_edge_n0", oe_active, 0);
    @(posedge MCLK);
    #1;
    chk("oe_edge_n1", oe_active, 1);
    repeat (99) @(negedge MCLK);
    hub.OE = 1'b1;
    repeat (10) @(negedge MCLK);
    chk("oe_active_cycles", oe_hi, 100);
    chk("oe_active_off", oe_active, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
